// File: rtl/clk_div_ctrl.sv
// ---------------------------------------------------------------------------
// clk_div_ctrl
//
// Divisor controller for the LF clock divider. It owns the divider's 8-bit
// divisor and arbitrates between a one-shot host configuration port and an
// internal frequency-sweep engine. Every divisor change is committed only at
// the clock edge that ends the divider's wrap cycle (div_cnt == divisor), so
// the divided clock never sees a runt or a stretched half-period.
//
// Ports
//   clk, reset          : system clock, synchronous active-high reset
//   cfg_valid/_divisor  : host request to set a divisor
//   cfg_ready           : host pending slot is empty
//   sweep_start         : pulse, samples sweep_lo/_hi/_dwell
//   sweep_busy          : sweep in progress
//   sweep_done          : one-cycle pulse on normal sweep completion
//   sweep_err           : one-cycle pulse when sweep_start is rejected
//   div_cnt, div_clk    : counter and divided clock fed back from the divider
//   divisor             : divisor driven to the divider
//   update_pulse        : high in the first cycle a new divisor is driven
// ---------------------------------------------------------------------------
module clk_div_ctrl #(
    parameter logic [7:0] RESET_DIVISOR = 8'd95
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cfg_valid,
    input  logic [7:0] cfg_divisor,
    output logic       cfg_ready,
    input  logic       sweep_start,
    input  logic [7:0] sweep_lo,
    input  logic [7:0] sweep_hi,
    input  logic [7:0] sweep_dwell,
    output logic       sweep_busy,
    output logic       sweep_done,
    output logic       sweep_err,
    input  logic [7:0] div_cnt,
    input  logic       div_clk,
    output logic [7:0] divisor,
    output logic       update_pulse
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_APPLY,
        S_DWELL,
        S_STEP
    } state_t;

    state_t     state_reg, state_next;

    logic [7:0] divisor_reg;
    logic       update_pulse_reg;
    logic       host_pend_valid_reg;
    logic [7:0] host_pend_val_reg;
    logic       sweep_pend_valid_reg;
    logic [7:0] sweep_pend_val_reg;
    logic       div_clk_q_reg;
    logic [7:0] cur_reg;
    logic [7:0] lo_reg;
    logic [7:0] hi_reg;
    logic [7:0] dwell_reg;
    logic [7:0] dwell_cnt_reg;
    logic       sweep_done_reg;
    logic       sweep_err_reg;

    logic       wrap;
    logic       host_accept;
    logic       host_apply;
    logic [7:0] host_value;
    logic       start_ok;
    logic       start_bad;
    logic       div_edge;
    logic       dwell_last;
    logic       sweep_apply;
    logic       done_next;
    logic       req_load;
    logic       req_step;

    // ------------------------------------------------------------------
    // Shared decode
    // ------------------------------------------------------------------
    assign cfg_ready   = ~host_pend_valid_reg;
    assign wrap        = (div_cnt == divisor_reg);
    assign host_accept = cfg_valid & cfg_ready;

    // A host request accepted during the wrap cycle bypasses the pending
    // slot and is committed at that same edge (minimum 1-cycle latency).
    assign host_apply  = wrap & (host_pend_valid_reg | host_accept);
    assign host_value  = host_pend_valid_reg ? host_pend_val_reg : cfg_divisor;

    // Host priority: a simultaneous host accept also rejects a start.
    assign start_ok    = sweep_start & (sweep_lo <= sweep_hi)
                         & ~host_pend_valid_reg & ~host_accept;
    assign start_bad   = sweep_start & ~start_ok;

    assign div_edge    = div_clk & ~div_clk_q_reg;
    assign dwell_last  = div_edge & (dwell_cnt_reg == dwell_reg);

    // A sweep value is committed only if nothing in this cycle (host
    // accept/abort or a sweep restart) discards it.
    assign sweep_apply = wrap & sweep_pend_valid_reg & (state_reg == S_WAIT_APPLY)
                         & ~host_apply & ~host_accept & ~start_ok;

    // ------------------------------------------------------------------
    // Sweep FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Sweep FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        done_next  = 1'b0;
        if (host_accept) begin
            state_next = S_IDLE;
        end else if (start_ok) begin
            state_next = S_LOAD;
        end else begin
            case (state_reg)
                S_IDLE:       state_next = S_IDLE;
                S_LOAD:       state_next = S_WAIT_APPLY;
                S_WAIT_APPLY: if (sweep_apply) state_next = S_DWELL;
                S_DWELL: begin
                    if (dwell_last) begin
                        if (cur_reg == hi_reg) begin
                            state_next = S_IDLE;
                            done_next  = 1'b1;
                        end else begin
                            state_next = S_STEP;
                        end
                    end
                end
                S_STEP:       state_next = S_WAIT_APPLY;
                default:      state_next = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sweep FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        sweep_busy = (state_reg != S_IDLE);
        req_load   = (state_reg == S_LOAD);
        req_step   = (state_reg == S_STEP);
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            divisor_reg          <= RESET_DIVISOR;
            update_pulse_reg     <= 1'b0;
            host_pend_valid_reg  <= 1'b0;
            host_pend_val_reg    <= 8'd0;
            sweep_pend_valid_reg <= 1'b0;
            sweep_pend_val_reg   <= 8'd0;
            div_clk_q_reg        <= 1'b0;
            cur_reg              <= 8'd0;
            lo_reg               <= 8'd0;
            hi_reg               <= 8'd0;
            dwell_reg            <= 8'd0;
            dwell_cnt_reg        <= 8'd0;
            sweep_done_reg       <= 1'b0;
            sweep_err_reg        <= 1'b0;
        end else begin
            div_clk_q_reg  <= div_clk;
            sweep_done_reg <= done_next;
            sweep_err_reg  <= start_bad;

            // Divisor commit: host value wins over a sweep value.
            if (host_apply) begin
                divisor_reg      <= host_value;
                update_pulse_reg <= 1'b1;
            end else if (sweep_apply) begin
                divisor_reg      <= sweep_pend_val_reg;
                update_pulse_reg <= 1'b1;
            end else begin
                update_pulse_reg <= 1'b0;
            end

            // Host pending slot.
            if (host_apply) begin
                host_pend_valid_reg <= 1'b0;
            end else if (host_accept) begin
                host_pend_valid_reg <= 1'b1;
                host_pend_val_reg   <= cfg_divisor;
            end

            // Sweep range capture.
            if (start_ok) begin
                lo_reg    <= sweep_lo;
                hi_reg    <= sweep_hi;
                dwell_reg <= sweep_dwell;
            end

            // Sweep pending slot and current step value.
            if (host_accept || start_ok || sweep_apply) begin
                sweep_pend_valid_reg <= 1'b0;
            end else if (req_load) begin
                cur_reg              <= lo_reg;
                sweep_pend_val_reg   <= lo_reg;
                sweep_pend_valid_reg <= 1'b1;
            end else if (req_step) begin
                cur_reg              <= cur_reg + 8'd1;
                sweep_pend_val_reg   <= cur_reg + 8'd1;
                sweep_pend_valid_reg <= 1'b1;
            end

            // Dwell counter: cleared when the step value lands, so the
            // divided-clock edge produced by that very apply is counted.
            if (sweep_apply) begin
                dwell_cnt_reg <= 8'd0;
            end else if ((state_reg == S_DWELL) && div_edge && !dwell_last) begin
                dwell_cnt_reg <= dwell_cnt_reg + 8'd1;
            end
        end
    end

    assign divisor      = divisor_reg;
    assign update_pulse = update_pulse_reg;
    assign sweep_done   = sweep_done_reg;
    assign sweep_err    = sweep_err_reg;

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Divisor controller for the LF clock divider. It owns the 8-bit `divisor` input of the divider and arbitrates between two requesters: a one-shot host configuration port and an internal frequency-sweep engine that steps the divisor across a range for antenna tuning. Every divisor change is applied only on the divider's wrap cycle, so the divided clock never produces a runt or stretched half-period. It sits between the FPGA configuration registers and the divider instance.

## Interface
Parameters:
- `RESET_DIVISOR`, default 8'd95: divisor driven out of reset (125 kHz from 24 MHz; divided period = 2·(divisor+1) clk cycles).

Ports:
- `clk` in 1: system clock. One clock domain only.
- `reset` in 1: synchronous, active-high reset.
- `cfg_valid` in 1: host request to set a divisor.
- `cfg_divisor` in 8: requested divisor, sampled when `cfg_valid & cfg_ready`.
- `cfg_ready` out 1: high when the host pending slot is empty.
- `sweep_start` in 1: single-cycle pulse that starts a sweep.
- `sweep_lo` in 8: first divisor of the sweep, sampled on `sweep_start`.
- `sweep_hi` in 8: last divisor of the sweep, sampled on `sweep_start`.
- `sweep_dwell` in 8: hold time per step in divided-clock rising edges, minus 1; sampled on `sweep_start`.
- `sweep_busy` out 1: sweep in progress.
- `sweep_done` out 1: one-cycle pulse when a sweep completes normally.
- `sweep_err` out 1: one-cycle pulse when `sweep_start` is rejected.
- `div_cnt` in 8: counter value fed back from the divider.
- `div_clk` in 1: divided clock fed back from the divider.
- `divisor` out 8: divisor driven to the divider.
- `update_pulse` out 1: one-cycle pulse in the first cycle a new `divisor` value is driven.

## Operation
- Reset values:
  - `divisor` = `RESET_DIVISOR`; `cfg_ready` = 1.
  - `sweep_busy`, `sweep_done`, `sweep_err` and `update_pulse` = 0.
  - The pending slot and the `div_clk` edge-detect register are cleared.
- Wrap cycle: the cycle in which `div_cnt == divisor`. A pending value is registered into `divisor` only at the clock edge that ends a wrap cycle.
- Host path:
  - The accept condition is `cfg_valid & cfg_ready`. On accept, `cfg_divisor` is latched into the pending slot and `cfg_ready` drops.
  - `cfg_ready` returns high in the cycle after the pending value is applied.
- Host priority: a host accept during a sweep aborts the sweep.
  - `sweep_busy` falls on the next edge.
  - No `sweep_done` pulse is issued.
  - Any sweep-pending value is discarded.
- Sweep FSM states: IDLE, LOAD, WAIT_APPLY, DWELL, STEP.
  - IDLE → LOAD on `sweep_start`, provided `sweep_lo <= sweep_hi` and the host slot is empty.
  - Otherwise, `sweep_start` pulses `sweep_err` for one cycle and the FSM stays in IDLE.
  - LOAD: set `cur = sweep_lo`, request apply of `cur`, go to WAIT_APPLY. `sweep_busy` = 1 from LOAD onward.
  - WAIT_APPLY → DWELL when the apply happens. The dwell counter is cleared at that point.
  - DWELL: count rising edges of `div_clk`, detected as `div_clk & ~div_clk_q`. When the count reaches `sweep_dwell` and another edge arrives (dwell+1 edges total):
    - if `cur == sweep_hi`, pulse `sweep_done`, drop `sweep_busy` and go to IDLE;
    - otherwise go to STEP.
  - STEP: `cur = cur + 1` (no wrap possible, since `cur < sweep_hi <= 255`), request apply, go to WAIT_APPLY.
- `sweep_start` while busy restarts the sweep from LOAD with the newly sampled range (same checks as in IDLE).
- Applying a value equal to the current `divisor` still takes the wrap-cycle path and still pulses `update_pulse`.
- After sweep completion or abort, `divisor` retains its last applied value.

## Timing
- Apply latency: from accept or request to the `divisor` change is at most (old divisor + 1) cycles, and at least 1 cycle.
- `divisor` and `update_pulse` change on the same edge. The divider counter reads 0 in that same cycle.
- Dwell edges are seen 1 cycle after the divider toggles `div_clk`, because of the edge-detect register.
- Simultaneous host accept and sweep apply in the same wrap cycle: the host value wins and is applied; the sweep is aborted.
- Reset asserted mid-operation: all state returns to reset values on the next edge, including `divisor` = `RESET_DIVISOR` immediately. It does not wait for a wrap cycle.

## Test plan
- Reset, then hold: `divisor` = 95, `cfg_ready` = 1; with the divider attached, `div_clk` period = 192 cycles.
- Host set 10 while `div_cnt` = 3: `cfg_ready` drops, `divisor` stays 95 until the wrap cycle, then becomes 10 with `update_pulse` = 1; the next `div_clk` half-period is exactly 11 cycles, with no runt.
- Sweep lo = 4, hi = 6, dwell = 1: `divisor` takes 4 → 5 → 6, each held for 2 `div_clk` rising edges; `sweep_done` pulses once, `sweep_busy` falls, `divisor` stays 6.
- `sweep_start` with lo = 9, hi = 8: `sweep_err` pulses for 1 cycle, `sweep_busy` stays 0, `divisor` is unchanged.
- Host accept of 20 during the DWELL of step 5: the sweep aborts with no `sweep_done`, and `divisor` becomes 20 at the next wrap.
- Reset asserted in WAIT_APPLY: next cycle `divisor` = 95, `sweep_busy` = 0, `cfg_ready` = 1, and no `update_pulse`.
